// File: rtl/slow_tick_receiver.sv
// slow_tick_receiver: brings the divided slow game clock into clk, turns each edge
// into a game tick, buffers ticks and hands them out over a valid/ready handshake.
module slow_tick_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter bit BOTH_EDGES  = 1'b1,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_in,
  input  logic              pause,
  input  logic              tick_ready,
  input  logic              clr_overrun,
  output logic              tick_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  tick_count,
  output logic              overrun
);
  localparam int                WARM_W    = 3;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic {WARMUP, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [WARM_W-1:0]      warm_reg, warm_next;
  logic [PEND_W-1:0]      pending_reg, pending_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic                   overrun_reg, overrun_next;
  logic                   sync_out;
  logic                   raw_evt;
  logic                   edge_evt;
  logic                   drop;
  logic                   take;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  generate
    if (BOTH_EDGES) begin : g_both_edges
      assign raw_evt = sync_out ^ prev_reg;
    end else begin : g_rise_only
      assign raw_evt = sync_out & ~prev_reg;
    end
  endgenerate

  assign tick_valid = (pending_reg != '0) & ~pause;
  assign take       = tick_valid & tick_ready;
  assign pending    = pending_reg;
  assign tick_count = count_reg;
  assign overrun    = overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= '0;
      prev_reg    <= 1'b0;
      state_reg   <= WARMUP;
      warm_reg    <= '0;
      pending_reg <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], slow_in};
      prev_reg    <= sync_out;
      state_reg   <= state_next;
      warm_reg    <= warm_next;
      pending_reg <= pending_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    warm_next    = warm_reg;
    pending_next = pending_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;
    edge_evt     = 1'b0;
    drop         = 1'b0;

    case (state_reg)
      // Hold off edge detection until prev has caught up with a settled sync chain.
      WARMUP: begin
        warm_next = warm_reg + 3'd1;
        if (warm_reg == WARM_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        edge_evt = raw_evt;
      end
      default: begin
        state_next = WARMUP;
      end
    endcase

    if (edge_evt && !take) begin
      if (pending_reg == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (!edge_evt && take) begin
      pending_next = pending_reg - 1'b1;
    end

    if (take) begin
      count_next = count_reg + 1'b1;
    end

    // A drop in the same cycle as a clear wins, so no lost tick goes unreported.
    overrun_next = drop | (overrun_reg & ~clr_overrun);
  end

endmodule

// File: tb/tb_slow_tick_receiver.sv
// Directed bench for slow_tick_receiver: stimulus pushes expected tick_count values
// for each delivery; a negedge monitor pops and compares on every take.
module tb_slow_tick_receiver;
  logic        clk = 1'b0;
  logic        rst, slow_in, pause, tick_ready, clr_overrun;
  logic        tv, ovr, tv4, ovr4;
  logic [2:0]  pend, pend4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int next_seq = 0;
  int mon_exp;

  always #5 clk = ~clk;

  slow_tick_receiver u_dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .pause(pause),
    .tick_ready(tick_ready), .clr_overrun(clr_overrun),
    .tick_valid(tv), .pending(pend), .tick_count(cnt), .overrun(ovr)
  );

  slow_tick_receiver #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .slow_in(slow_in), .pause(pause),
    .tick_ready(tick_ready), .clr_overrun(clr_overrun),
    .tick_valid(tv4), .pending(pend4), .tick_count(cnt4), .overrun(ovr4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic st(input string name, input logic v, input int p, input logic o);
    chk({name, " valid"}, 32'(tv), 32'(v));
    chk({name, " pending"}, 32'(pend), 32'(p));
    chk({name, " overrun"}, 32'(ovr), 32'(o));
    chk({name, " valid4"}, 32'(tv4), 32'(v));
    chk({name, " pending4"}, 32'(pend4), 32'(p));
    chk({name, " overrun4"}, 32'(ovr4), 32'(o));
  endtask

  task automatic push(input int n);
    repeat (n) begin
      exp_q.push_back(next_seq);
      next_seq++;
    end
  endtask

  // Scoreboard monitor: every take must match the next queued delivery number.
  always @(negedge clk) begin
    if (!rst && tv && tick_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL take_unexpected: tick_count %0d, no delivery expected", cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("take count", 32'(cnt), 32'(mon_exp & 16'hFFFF));
        chk("take count4", 32'(cnt4), 32'(mon_exp & 15));
        chk("take valid4", 32'(tv4), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; slow_in = 1'b1; pause = 1'b0; tick_ready = 1'b0; clr_overrun = 1'b0;
    cyc(3);
    st("reset", 1'b0, 0, 1'b0);
    chk("reset count", 32'(cnt), 32'd0);
    chk("reset count4", 32'(cnt4), 32'd0);

    // 1: slow_in high through reset must not produce a tick
    rst = 1'b0;
    tick_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("warmup valid", 32'(tv), 32'd0);
    end
    st("warmup end", 1'b0, 0, 1'b0);

    // 2: latency and one-cycle pulses with consumer always ready
    for (int i = 0; i < 4; i++) begin
      slow_in = ~slow_in;
      push(1);
      cyc(1); chk("lat k valid", 32'(tv), 32'd0);
      cyc(1); chk("lat k+1 valid", 32'(tv), 32'd0);
      cyc(1); chk("lat k+2 valid", 32'(tv), 32'd1);
      cyc(1); chk("lat k+3 valid", 32'(tv), 32'd0);
      cyc(16);
    end
    chk("count after 4", 32'(cnt), 32'd4);

    // 3: saturation, overrun, clear, and set-beats-clear
    tick_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      slow_in = ~slow_in;
      cyc(12);
      st("fill", 1'b1, (i > 7) ? 7 : i, (i >= 8) ? 1'b1 : 1'b0);
    end
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
    st("clr", 1'b1, 7, 1'b0);
    slow_in = ~slow_in;
    cyc(2);
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
    st("set and clr", 1'b1, 7, 1'b1);
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
    st("clr2", 1'b1, 7, 1'b0);
    cyc(8);
    push(7);
    tick_ready = 1'b1; cyc(7); tick_ready = 1'b0;
    st("drain7", 1'b0, 0, 1'b0);
    chk("count after drain7", 32'(cnt), 32'd11);

    // 4: edge coinciding with a take leaves pending unchanged
    slow_in = ~slow_in; cyc(12);
    slow_in = ~slow_in; cyc(12);
    st("pend2", 1'b1, 2, 1'b0);
    slow_in = ~slow_in;
    push(1);
    cyc(2);
    tick_ready = 1'b1; cyc(1); tick_ready = 1'b0;
    st("edge and take", 1'b1, 2, 1'b0);
    chk("count edge and take", 32'(cnt), 32'd12);
    cyc(12);
    push(2);
    tick_ready = 1'b1; cyc(2); tick_ready = 1'b0;
    st("drain2", 1'b0, 0, 1'b0);

    // 5: pause accumulates, release delivers back-to-back
    pause = 1'b1;
    tick_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      slow_in = ~slow_in;
      cyc(12);
      st("paused", 1'b0, i, 1'b0);
    end
    push(3);
    pause = 1'b0;
    #1;
    chk("unpause valid", 32'(tv), 32'd1);
    cyc(1); chk("unpause pend 2", 32'(pend), 32'd2);
    cyc(1); chk("unpause pend 1", 32'(pend), 32'd1);
    cyc(1); st("unpause done", 1'b0, 0, 1'b0);
    tick_ready = 1'b0;
    chk("count 17", 32'(cnt), 32'd17);
    chk("count4 wrapped", 32'(cnt4), 32'd1);

    // 6: reset with ticks pending discards them silently
    for (int i = 1; i <= 5; i++) begin
      slow_in = ~slow_in;
      cyc(12);
    end
    st("pend5", 1'b1, 5, 1'b0);
    rst = 1'b1; cyc(1);
    st("mid reset", 1'b0, 0, 1'b0);
    chk("mid reset count", 32'(cnt), 32'd0);
    chk("mid reset count4", 32'(cnt4), 32'd0);
    rst = 1'b0;
    tick_ready = 1'b1;
    cyc(20);
    st("post reset", 1'b0, 0, 1'b0);
    chk("post reset count", 32'(cnt), 32'd0);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
